// File: rtl/gfx_mem_arbiter.sv
// gfx_mem_arbiter: four-port read arbiter in front of a single-port synchronous RAM.
// Define GFX_MEM_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise port 0 has fixed highest priority.
module gfx_mem_arbiter #(
    parameter int ADDRESS_BITS = 16,
    parameter int BITS         = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDRESS_BITS-1:0] spcon_memory_address,
    input  logic [ADDRESS_BITS-1:0] bg0_memory_address,
    input  logic [ADDRESS_BITS-1:0] bg1_memory_address,
    input  logic [ADDRESS_BITS-1:0] ov_memory_address,
    input  logic                    spcon_rvalid,
    input  logic                    bg0_rvalid,
    input  logic                    bg1_rvalid,
    input  logic                    ov_rvalid,
    output logic [BITS-1:0]         spcon_memory_data,
    output logic [BITS-1:0]         bg0_memory_data,
    output logic [BITS-1:0]         bg1_memory_data,
    output logic [BITS-1:0]         ov_memory_data,
    output logic                    spcon_rready,
    output logic                    bg0_rready,
    output logic                    bg1_rready,
    output logic                    ov_rready,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic                    mem_rd,
    input  logic [BITS-1:0]         mem_data,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, READ, CAPTURE, DONE} state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [1:0]              r_grant;
    logic [ADDRESS_BITS-1:0] r_addr;
    logic [BITS-1:0]         r_data [4];
    logic [3:0]              w_rvalid;
    logic [ADDRESS_BITS-1:0] w_portAddr [4];
    logic                    w_anyReq;
    logic [1:0]              w_grantSel;
    logic [3:0]              w_rready;

    assign w_rvalid      = {ov_rvalid, bg1_rvalid, bg0_rvalid, spcon_rvalid};
    assign w_portAddr[0] = spcon_memory_address;
    assign w_portAddr[1] = bg0_memory_address;
    assign w_portAddr[2] = bg1_memory_address;
    assign w_portAddr[3] = ov_memory_address;
    assign w_anyReq      = |w_rvalid;

`ifdef GFX_MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] r_lastServed;

    // Scan downward so the nearest requester after the last-served port wins.
    always_comb begin
        w_grantSel = r_lastServed;
        for (int k = 4; k >= 1; k--) begin
            if (w_rvalid[2'(int'(r_lastServed) + k)]) begin
                w_grantSel = 2'(int'(r_lastServed) + k);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lastServed <= 2'd3;
        end else if (r_state == IDLE && w_anyReq) begin
            r_lastServed <= w_grantSel;
        end
    end
`else
    always_comb begin
        w_grantSel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rvalid[k]) begin
                w_grantSel = 2'(k);
            end
        end
    end
`endif

    // Address is latched with the grant so requester changes mid-transaction are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_grant <= 2'd0;
            r_addr  <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_anyReq) begin
                r_grant <= w_grantSel;
                r_addr  <= w_portAddr[w_grantSel];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int p = 0; p < 4; p++) begin
                r_data[p] <= '0;
            end
        end else if (r_state == CAPTURE) begin
            r_data[r_grant] <= mem_data;
        end
    end

    always_comb begin
        w_nextState = r_state;
        mem_rd      = 1'b0;
        mem_address = '0;
        w_rready    = 4'b0000;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_anyReq) begin
                    w_nextState = READ;
                end
            end
            READ: begin
                mem_rd      = 1'b1;
                mem_address = r_addr;
                w_nextState = CAPTURE;
            end
            CAPTURE: begin
                w_nextState = DONE;
            end
            DONE: begin
                w_rready[r_grant] = 1'b1;
                w_nextState       = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign spcon_rready      = w_rready[0];
    assign bg0_rready        = w_rready[1];
    assign bg1_rready        = w_rready[2];
    assign ov_rready         = w_rready[3];
    assign spcon_memory_data = r_data[0];
    assign bg0_memory_data   = r_data[1];
    assign bg1_memory_data   = r_data[2];
    assign ov_memory_data    = r_data[3];
endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// tb_gfx_mem_arbiter: directed and randomized checks of gfx_mem_arbiter against a transaction-level model.
// Honors GFX_MEM_ARB_ROUND_ROBIN_EN to pick the expected grant policy.
module tb_gfx_mem_arbiter;
`ifdef GFX_MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [3:0]        rv = 4'b0000;
    logic [3:0][15:0]  addr = '0;
    wire  [3:0][15:0]  dout;
    wire  [3:0]        rdy;
    wire  [15:0]       mem_address;
    wire               mem_rd;
    wire               busy;
    logic [15:0]       mem_data = 16'h0000;
    logic [15:0]       ram [0:65535];

    int passCount  = 0;
    int checkCount = 0;

    gfx_mem_arbiter #(.ADDRESS_BITS(16), .BITS(16)) dut (
        .CLK(CLK), .RST(RST),
        .spcon_memory_address(addr[0]), .bg0_memory_address(addr[1]),
        .bg1_memory_address(addr[2]),   .ov_memory_address(addr[3]),
        .spcon_rvalid(rv[0]), .bg0_rvalid(rv[1]), .bg1_rvalid(rv[2]), .ov_rvalid(rv[3]),
        .spcon_memory_data(dout[0]), .bg0_memory_data(dout[1]),
        .bg1_memory_data(dout[2]),   .ov_memory_data(dout[3]),
        .spcon_rready(rdy[0]), .bg0_rready(rdy[1]), .bg1_rready(rdy[2]), .ov_rready(rdy[3]),
        .mem_address(mem_address), .mem_rd(mem_rd), .mem_data(mem_data), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_rd) mem_data <= ram[mem_address];
    end

    // Transaction model: age counts cycles since the grant (-1 = no transaction in flight).
    int          mAge  = -1;
    int          mPort = 0;
    logic [15:0] mAddr = 16'h0;
    int          mLast = 3;
    logic [15:0] mData [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    bit          modelOn = 1'b0;

    function automatic int pickPort(input logic [3:0] req, input int last);
        for (int k = 0; k < 4; k++) begin
            int p;
            p = RR_EN ? (last + 1 + k) % 4 : k;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mAge = -1;
            mLast = 3;
            for (int p = 0; p < 4; p++) mData[p] = 16'h0;
        end else if (mAge < 0) begin
            if (rv != 4'b0000) begin
                mPort = pickPort(rv, mLast);
                mAddr = addr[mPort];
                mLast = mPort;
                mAge  = 0;
            end
        end else if (mAge == 2) begin
            mAge = -1;
        end else begin
            if (mAge == 1) mData[mPort] = ram[mAddr];
            mAge = mAge + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (modelOn) begin
            logic [3:0] expRdy;
            expRdy = (mAge == 2) ? 4'(1 << mPort) : 4'b0000;
            checkOutput("model_ctrl", {busy, mem_rd, mem_address, rdy},
                        {(mAge >= 0), (mAge == 0), (mAge == 0) ? mAddr : 16'h0, expRdy});
            checkOutput("model_data", dout, {mData[3], mData[2], mData[1], mData[0]});
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic [15:0] a);
        rv[port]   = 1'b1;
        addr[port] = a;
    endtask

    task automatic doReset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int viol;
        int pulsePort [8];
        int pulseCyc  [8];
        int nPulse;

        for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
        ram[16'h1234] = 16'hBEEF;
        ram[16'h0300] = 16'h00AA;
        ram[16'h0400] = 16'h5555;
        ram[16'h0010] = 16'h1111;
        ram[16'h0020] = 16'h2222;

        #2;
        doReset();
        modelOn = 1'b1;
        checkOutput("reset_ctrl", {busy, mem_rd, mem_address, rdy}, 64'h0);
        checkOutput("reset_data", dout, 64'h0);

        // Single bg0 read
        applyStimulus(1, 16'h1234);
        tick();
        checkOutput("bg0_read_strobe", {mem_rd, busy, mem_address}, {1'b1, 1'b1, 16'h1234});
        tick();
        checkOutput("bg0_no_early_rdy", rdy, 4'b0000);
        tick();
        checkOutput("bg0_rready", rdy, 4'b0010);
        checkOutput("bg0_data", dout[1], 16'hBEEF);
        checkOutput("model_pin_bg0", mData[1], 16'hBEEF);
        rv[1] = 1'b0;
        tick();
        checkOutput("bg0_data_held", {busy, rdy, dout[1]}, {1'b0, 4'b0000, 16'hBEEF});

        // ov then spcon: ov data register must not be disturbed
        applyStimulus(3, 16'h0300);
        tick(); tick(); tick();
        checkOutput("ov_data", {rdy, dout[3]}, {4'b1000, 16'h00AA});
        rv[3] = 1'b0;
        tick();
        applyStimulus(0, 16'h0400);
        tick(); tick(); tick();
        checkOutput("spcon_data", {rdy, dout[0]}, {4'b0001, 16'h5555});
        checkOutput("ov_data_kept", dout[3], 16'h00AA);
        rv[0] = 1'b0;
        tick();

        // bg1 address changes while in READ
        applyStimulus(2, 16'h0010);
        tick();
        addr[2] = 16'h0020;
        #1;
        checkOutput("bg1_addr_latched", mem_address, 16'h0010);
        tick(); tick();
        checkOutput("bg1_data", {rdy, dout[2]}, {4'b0100, 16'h1111});
        rv[2] = 1'b0;
        tick();

        // Reset during CAPTURE of a bg0 read
        doReset();
        applyStimulus(1, 16'h1234);
        tick(); tick();
        RST = 1'b1;
        #1;
        checkOutput("rst_capture", {busy, rdy, dout[1]}, {1'b0, 4'b0000, 16'h0});
        tick();
        checkOutput("rst_no_rdy", {busy, rdy}, 5'b0);
        RST = 1'b0;
        tick(); tick(); tick();
        checkOutput("rst_rerequest", {rdy, dout[1]}, {4'b0010, 16'hBEEF});
        rv[1] = 1'b0;
        tick();

        // Quiet interval
        viol = 0;
        rv = 4'b0000;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mem_rd !== 1'b0 || busy !== 1'b0 || rdy !== 4'b0000) viol++;
        end
        checkOutput("idle100_violations", viol, 0);

        // All four held high continuously
        doReset();
        for (int p = 0; p < 4; p++) applyStimulus(p, 16'(16'h0100 + p));
        nPulse = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (rdy != 4'b0000 && nPulse < 8) begin
                pulseCyc[nPulse] = t;
                pulsePort[nPulse] = -1;
                for (int p = 0; p < 4; p++) if (rdy[p]) pulsePort[nPulse] = p;
                nPulse++;
            end
        end
        checkOutput("allreq_pulse_count", nPulse, 5);
        for (int k = 0; k < 5; k++) begin
            int gotPort;
            int gotCyc;
            gotPort = (k < nPulse) ? pulsePort[k] : -1;
            gotCyc  = (k < nPulse) ? pulseCyc[k] : -1;
            checkOutput($sformatf("allreq_order_%0d", k), gotPort, RR_EN ? k % 4 : 0);
            checkOutput($sformatf("allreq_cycle_%0d", k), gotCyc, 3 + 4 * k);
        end
        rv = 4'b0000;
        tick(); tick(); tick(); tick();

        // Randomized requesters obeying the hold-until-served rule
        doReset();
        for (int i = 0; i < 1500; i++) begin
            tick();
            if ($urandom_range(0, 299) == 0) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
            end
            for (int p = 0; p < 4; p++) begin
                if (rv[p] && rdy[p]) begin
                    if ($urandom_range(0, 3) != 0) rv[p] = 1'b0;
                end else if (!rv[p] && $urandom_range(0, 3) == 0) begin
                    applyStimulus(p, 16'($urandom));
                end
            end
        end
        rv = 4'b0000;
        tick(); tick(); tick(); tick(); tick();
        modelOn = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
